// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID decoupling FIFO carrying fetched pc/inst with decoded register fields.
// Define IF_ID_QUEUE_BYPASS_EN to present an offer on an empty queue in the same cycle.
module if_id_queue #(
    parameter int PC_WIDTH       = 32,
    parameter int INST_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      IF_flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PC_WIDTH-1:0]       pc,
    input  logic [INST_WIDTH-1:0]     inst,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_WIDTH-1:0]       IF_ID_pc,
    output logic [INST_WIDTH-1:0]     IF_ID_inst,
    output logic [6:0]                IF_ID_inst_opcode,
    output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    output logic [REG_ADDR_WIDTH-1:0] IF_ID_rd,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PC_WIDTH-1:0]   r_pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_consume;
    logic w_wr_en;
    logic w_rd_en;

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != CNT_W'(DEPTH));
    assign count    = r_count;

`ifdef IF_ID_QUEUE_BYPASS_EN
    logic w_bypass;

    // Reset gating keeps the outputs quiet while reset is held with an offer pending.
    assign w_bypass  = w_empty & in_valid & ~IF_flush & ~reset;
    assign out_valid = ~w_empty | w_bypass;
    assign w_consume = w_bypass & out_ready;

    always_comb begin
        IF_ID_pc   = '0;
        IF_ID_inst = '0;
        if (!w_empty) begin
            IF_ID_pc   = r_pc_mem[r_rd_ptr];
            IF_ID_inst = r_inst_mem[r_rd_ptr];
        end else if (w_bypass) begin
            IF_ID_pc   = pc;
            IF_ID_inst = inst;
        end
    end
`else
    assign out_valid = ~w_empty;
    assign w_consume = 1'b0;

    always_comb begin
        IF_ID_pc   = '0;
        IF_ID_inst = '0;
        if (!w_empty) begin
            IF_ID_pc   = r_pc_mem[r_rd_ptr];
            IF_ID_inst = r_inst_mem[r_rd_ptr];
        end
    end
`endif

    assign IF_ID_inst_opcode = IF_ID_inst[6:0];
    assign IF_ID_rs1         = IF_ID_inst[15 +: REG_ADDR_WIDTH];
    assign IF_ID_rs2         = IF_ID_inst[20 +: REG_ADDR_WIDTH];
    assign IF_ID_rd          = IF_ID_inst[7 +: REG_ADDR_WIDTH];

    assign w_push = in_valid & in_ready & ~IF_flush;
    assign w_pop  = out_valid & out_ready & ~IF_flush;

    // A bypassed entry taken in the same cycle never touches storage or pointers.
    assign w_wr_en = w_push & ~w_consume;
    assign w_rd_en = w_pop & ~w_consume;

    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            r_pc_mem[r_wr_ptr]   <= pc;
            r_inst_mem[r_wr_ptr] <= inst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || IF_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_wr_en && !w_rd_en) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_wr_en && w_rd_en) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue.sv - self-checking bench for if_id_queue with a scoreboard monitor.
// Honors IF_ID_QUEUE_BYPASS_EN when defined for both bench and design.
module tb_if_id_queue;

    localparam int PW    = 32;
    localparam int IW    = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
`ifdef IF_ID_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          IF_flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] pc = '0;
    logic [IW-1:0] inst = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] IF_ID_pc;
    logic [IW-1:0] IF_ID_inst;
    logic [6:0]    IF_ID_inst_opcode;
    logic [RW-1:0] IF_ID_rs1;
    logic [RW-1:0] IF_ID_rs2;
    logic [RW-1:0] IF_ID_rd;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [PW-1:0] sb_pc[$];
    logic [IW-1:0] sb_inst[$];
    int            m_count = 0;
    bit            mon_en = 1'b0;
    bit            m_in_rdy;
    bit            m_byp;
    bit            m_ov;
    logic [PW-1:0] e_pc;
    logic [IW-1:0] e_inst;

    if_id_queue #(.PC_WIDTH(PW), .INST_WIDTH(IW), .REG_ADDR_WIDTH(RW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .IF_flush(IF_flush),
        .in_valid(in_valid), .in_ready(in_ready), .pc(pc), .inst(inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst),
        .IF_ID_inst_opcode(IF_ID_inst_opcode), .IF_ID_rs1(IF_ID_rs1),
        .IF_ID_rs2(IF_ID_rs2), .IF_ID_rd(IF_ID_rd), .count(count)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare at the falling edge, then advance the model for the next rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            m_in_rdy = (m_count != DEPTH);
            m_byp    = BYP && (m_count == 0) && in_valid && !IF_flush && !reset;
            m_ov     = (m_count != 0) || m_byp;
            if (m_byp) begin
                e_pc = pc; e_inst = inst;
            end else if (m_count != 0) begin
                e_pc = sb_pc[0]; e_inst = sb_inst[0];
            end else begin
                e_pc = '0; e_inst = '0;
            end
            n_checks++;
            if (count !== CW'(m_count)) $display("FAIL mon_count t=%0t got %0d exp %0d", $time, count, m_count);
            else n_pass++;
            n_checks++;
            if (in_ready !== m_in_rdy) $display("FAIL mon_in_ready t=%0t got %b exp %b", $time, in_ready, m_in_rdy);
            else n_pass++;
            n_checks++;
            if (out_valid !== m_ov) $display("FAIL mon_out_valid t=%0t got %b exp %b", $time, out_valid, m_ov);
            else n_pass++;
            n_checks++;
            if (IF_ID_pc !== e_pc) $display("FAIL mon_pc t=%0t got %h exp %h", $time, IF_ID_pc, e_pc);
            else n_pass++;
            n_checks++;
            if (IF_ID_inst !== e_inst) $display("FAIL mon_inst t=%0t got %h exp %h", $time, IF_ID_inst, e_inst);
            else n_pass++;
            if (reset || IF_flush) begin
                sb_pc.delete(); sb_inst.delete(); m_count = 0;
            end else if (!(m_byp && out_ready)) begin
                if (m_ov && out_ready) begin
                    void'(sb_pc.pop_front()); void'(sb_inst.pop_front()); m_count--;
                end
                if (in_valid && m_in_rdy) begin
                    sb_pc.push_back(pc); sb_inst.push_back(inst); m_count++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; pc = 32'h99; inst = 32'hFFFF_FFFF; out_ready = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else n_pass++;
        n_checks++;
        if (count !== '0) $display("FAIL rst_count got %0d exp 0", count); else n_pass++;
        n_checks++;
        if (IF_ID_inst !== '0) $display("FAIL rst_inst got %h exp 0", IF_ID_inst); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; pc = 32'(i * 4); inst = 32'h13 + 32'(i);
            tick();
        end
        pc = 32'h10; inst = 32'h77;
        @(negedge clk);
        n_checks++;
        if (count !== CW'(4)) $display("FAIL fill_count got %0d exp 4", count); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL fill_in_ready got %b exp 0", in_ready); else n_pass++;
        n_checks++;
        if (IF_ID_pc !== 32'h0) $display("FAIL fill_head got %h exp 0", IF_ID_pc); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== CW'(4)) $display("FAIL fill_5th_count got %0d exp 4", count); else n_pass++;
        n_checks++;
        if (IF_ID_pc !== 32'h0) $display("FAIL fill_5th_head got %h exp 0", IF_ID_pc); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_drain_push();
        logic [PW-1:0] exp_pc [4];
        logic [PW-1:0] offer  [4];
        int            exp_cnt[4];
        exp_pc  = '{32'h00, 32'h04, 32'h08, 32'h0C};
        offer   = '{32'h10, 32'h10, 32'h14, 32'h18};
        exp_cnt = '{4, 3, 3, 3};
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; out_ready = 1'b1; pc = offer[k]; inst = 32'h100 + 32'(k);
            @(negedge clk);
            n_checks++;
            if (IF_ID_pc !== exp_pc[k]) $display("FAIL drain_head%0d got %h exp %h", k, IF_ID_pc, exp_pc[k]);
            else n_pass++;
            n_checks++;
            if (count !== CW'(exp_cnt[k])) $display("FAIL drain_count%0d got %0d exp %0d", k, count, exp_cnt[k]);
            else n_pass++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== CW'(3)) $display("FAIL wrap_count got %0d exp 3", count); else n_pass++;
        n_checks++;
        if (IF_ID_pc !== 32'h10) $display("FAIL wrap_head got %h exp 10", IF_ID_pc); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        IF_flush = 1'b1; in_valid = 1'b1; pc = 32'h20; inst = 32'h2020; out_ready = 1'b0;
        tick();
        IF_flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== '0) $display("FAIL flush_count got %0d exp 0", count); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++;
        if (IF_ID_pc !== '0) $display("FAIL flush_pc got %h exp 0", IF_ID_pc); else n_pass++;
        @(posedge clk); #1;
        tick();
    endtask

    task automatic test_decode();
        in_valid = 1'b1; pc = 32'h80; inst = 32'h00B5_0533; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (IF_ID_inst_opcode !== 7'h33) $display("FAIL dec_opcode got %h exp 33", IF_ID_inst_opcode); else n_pass++;
        n_checks++;
        if (IF_ID_rs1 !== 5'd10) $display("FAIL dec_rs1 got %0d exp 10", IF_ID_rs1); else n_pass++;
        n_checks++;
        if (IF_ID_rs2 !== 5'd11) $display("FAIL dec_rs2 got %0d exp 11", IF_ID_rs2); else n_pass++;
        n_checks++;
        if (IF_ID_rd !== 5'd10) $display("FAIL dec_rd got %0d exp 10", IF_ID_rd); else n_pass++;
        @(posedge clk); #1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (IF_ID_inst_opcode !== 7'h0) $display("FAIL dec_empty_opcode got %h exp 0", IF_ID_inst_opcode); else n_pass++;
        n_checks++;
        if (IF_ID_rd !== 5'd0) $display("FAIL dec_empty_rd got %0d exp 0", IF_ID_rd); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_bypass_latency();
        in_valid = 1'b1; out_ready = 1'b1; pc = 32'h40; inst = 32'h13;
        @(negedge clk);
        n_checks++;
        if (out_valid !== BYP) $display("FAIL lat_out_valid got %b exp %b", out_valid, BYP); else n_pass++;
        n_checks++;
        if (IF_ID_pc !== (BYP ? 32'h40 : 32'h0)) $display("FAIL lat_pc got %h exp %h", IF_ID_pc, BYP ? 32'h40 : 32'h0);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== CW'(BYP ? 0 : 1)) $display("FAIL lat_count got %0d exp %0d", count, BYP ? 0 : 1); else n_pass++;
        @(posedge clk); #1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 63) == 0);
            IF_flush  = ($urandom_range(0, 31) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) == 1);
            pc        = $urandom;
            inst      = $urandom;
            tick();
        end
        reset = 1'b0; IF_flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && m_count != 0; c++) tick();
        n_checks++;
        if (m_count != 0 || count !== '0) $display("FAIL drain_timeout got %0d exp 0", count); else n_pass++;
        out_ready = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t exp finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain_push();
        test_flush();
        test_decode();
        test_bypass_latency();
        test_back_to_back();
        @(posedge clk); #1;
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
